// File: rtl/taptempo_pkg.sv
// Shared TapTempo definitions: FSM state codes, default timing parameters,
// and the counter width helper used by the debouncer, tap_period and BPM blocks.
package taptempo_pkg;

   typedef logic [1:0] state_t;

   // s_wait is reserved; the FSM never enters it and falls back to s_idle.
   localparam state_t s_idle  = 2'd0;
   localparam state_t s_count = 2'd1;
   localparam state_t s_wait  = 2'd2;

   localparam int PULSE_PER_NS_DEF = 5120;
   localparam int MIN_PER_NS_DEF   = 250_000_000;
   localparam int MAX_PER_NS_DEF   = 1_500_000_000;

   // Bits needed to hold every value from 0 up to and including max_value.
   function automatic int count_width(input int max_value);
      return $clog2(max_value + 1);
   endfunction

endpackage

// File: rtl/tap_average.sv
// Four-deep running average of accepted tap periods (built only when
// TAP_AVERAGE_EN is defined); the average reflects the history after this load.
`ifdef TAP_AVERAGE_EN
module tap_average
   import taptempo_pkg::*;
#(
   parameter int W = 8
) (
   input  logic         clk_i,
   input  logic         rst_i,
   input  logic         load_i,
   input  logic         clear_i,
   input  logic [W-1:0] period_i,
   output logic [W-1:0] average_o
);

   logic [W-1:0] hist   [4];
   logic [W-1:0] hist_n [4];
   logic         primed;
   logic [W+1:0] sum;

   // First period after idle fills the whole history so the average starts exact.
   always_comb begin
      hist_n[0] = period_i;
      for (int i = 1; i < 4; i++) begin
         hist_n[i] = primed ? hist[i-1] : period_i;
      end
      sum = {2'b00, hist_n[0]} + {2'b00, hist_n[1]} +
            {2'b00, hist_n[2]} + {2'b00, hist_n[3]};
      average_o = sum[W+1:2];
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         primed <= 1'b0;
         for (int i = 0; i < 4; i++) hist[i] <= '0;
      end else if (clear_i) begin
         primed <= 1'b0;
      end else if (load_i) begin
         primed <= 1'b1;
         for (int i = 0; i < 4; i++) hist[i] <= hist_n[i];
      end
   end

endmodule
`endif

// File: rtl/tap_period.sv
// Measures the interval between debounced button taps in tp_i units and hands
// each accepted interval downstream; define TAP_AVERAGE_EN to output a 4-tap average.
module tap_period
   import taptempo_pkg::*;
#(
   parameter  int PULSE_PER_NS = PULSE_PER_NS_DEF,
   parameter  int MIN_PER_NS   = MIN_PER_NS_DEF,
   parameter  int MAX_PER_NS   = MAX_PER_NS_DEF,
   localparam int MIN_COUNT    = MIN_PER_NS / PULSE_PER_NS,
   localparam int MAX_COUNT    = MAX_PER_NS / PULSE_PER_NS,
   localparam int PERIOD_W     = count_width(MAX_COUNT)
) (
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic                tp_i,
   input  logic                btn_i,
   output logic [PERIOD_W-1:0] period_o,
   output logic                period_valid_o,
   input  logic                period_ready_i,
   output logic                timeout_o,
   output logic                overrun_o,
   output logic [1:0]          state_o
);

   localparam logic [PERIOD_W-1:0] MIN_CNT = PERIOD_W'(MIN_COUNT);
   localparam logic [PERIOD_W-1:0] MAX_CNT = PERIOD_W'(MAX_COUNT);
   localparam logic [PERIOD_W-1:0] ONE     = PERIOD_W'(1);

   logic                btn_d;
   logic                tap;
   logic                accept;
   logic                timeout;
   state_t              state, state_n;
   logic [PERIOD_W-1:0] count, count_n, count_inc;
   logic [PERIOD_W-1:0] out_period;

   assign tap       = btn_i & ~btn_d;
   assign count_inc = (tp_i && count != MAX_CNT) ? count + ONE : count;
   assign state_o   = state;

   // On an accepting tap the current count is the period; a tp_i in the same
   // cycle already belongs to the next interval, hence the reload to 1.
   always_comb begin
      state_n = state;
      count_n = count;
      accept  = 1'b0;
      timeout = 1'b0;
      case (state)
         s_idle: begin
            count_n = '0;
            if (tap) begin
               state_n = s_count;
               count_n = tp_i ? ONE : '0;
            end
         end
         s_count: begin
            if (tap && count >= MIN_CNT) begin
               accept  = 1'b1;
               count_n = tp_i ? ONE : '0;
            end else if (!tap && tp_i && count == MAX_CNT) begin
               state_n = s_idle;
               timeout = 1'b1;
               count_n = '0;
            end else begin
               count_n = count_inc;
            end
         end
         default: begin
            state_n = s_idle;
            count_n = '0;
         end
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state <= s_idle;
         count <= '0;
         btn_d <= 1'b0;
      end else begin
         state <= state_n;
         count <= count_n;
         btn_d <= btn_i;
      end
   end

`ifdef TAP_AVERAGE_EN
   tap_average #(
      .W (PERIOD_W)
   ) u_tap_average (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .load_i    (accept),
      .clear_i   (timeout),
      .period_i  (count),
      .average_o (out_period)
   );
`else
   assign out_period = count;
`endif

   // Handshake: period_o is held while valid & !ready; a transfer happens on any
   // edge with valid & ready; a new period overwrites a stalled one and flags overrun.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         period_o       <= '0;
         period_valid_o <= 1'b0;
         timeout_o      <= 1'b0;
         overrun_o      <= 1'b0;
      end else begin
         timeout_o <= timeout;
         overrun_o <= 1'b0;
         if (accept) begin
            period_o       <= out_period;
            period_valid_o <= 1'b1;
            overrun_o      <= period_valid_o & ~period_ready_i;
         end else if (period_valid_o && period_ready_i) begin
            period_valid_o <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_tap_period.sv
// Bench for tap_period: directed scenarios plus a randomized tap stream checked
// against a timestamp-based reference model; define TAP_AVERAGE_EN to check averaging.
module tb_tap_period;
   import taptempo_pkg::*;

   localparam int MIN_C = 10;
   localparam int MAX_C = 100;
   localparam int W     = 7;

   logic         clk = 1'b0;
   logic         rst_i;
   logic         tp_i;
   logic         btn_i;
   logic [W-1:0] period_o;
   logic         period_valid_o;
   logic         period_ready_i;
   logic         timeout_o;
   logic         overrun_o;
   logic [1:0]   state_o;

   always #5 clk = ~clk;

   tap_period #(
      .PULSE_PER_NS (5120),
      .MIN_PER_NS   (51200),
      .MAX_PER_NS   (512000)
   ) dut (
      .clk_i          (clk),
      .rst_i          (rst_i),
      .tp_i           (tp_i),
      .btn_i          (btn_i),
      .period_o       (period_o),
      .period_valid_o (period_valid_o),
      .period_ready_i (period_ready_i),
      .timeout_o      (timeout_o),
      .overrun_o      (overrun_o),
      .state_o        (state_o)
   );

   int total = 0;
   int bad   = 0;

   // Reference model: intervals are differences of a running tp_i timestamp.
   bit           m_meas, m_btn, m_valid, m_primed;
   int           m_tp, m_start;
   logic [W-1:0] m_period;
`ifdef TAP_AVERAGE_EN
   int           m_hist [4];
`endif
   int           exp_to, exp_ov, obs_to, obs_ov;
   logic [W-1:0] exp_q[$];
   logic [W-1:0] got_q[$];

   task automatic cycle(input logic b, input logic t);
      bit tap, acc;
      int per, val;
      btn_i = b;
      tp_i  = t;
      tap   = b && !m_btn;
      m_btn = b;
      acc   = 0;
      per   = 0;
      val   = 0;
      if (m_meas) begin
         if (tap && (m_tp - m_start) >= MIN_C) begin
            acc     = 1;
            per     = m_tp - m_start;
            m_start = m_tp;
         end else if (!tap && t && (m_tp - m_start) == MAX_C) begin
            m_meas   = 0;
            m_primed = 0;
            exp_to++;
         end
      end else if (tap) begin
         m_meas  = 1;
         m_start = m_tp;
      end
      if (t) m_tp++;
      if (acc) begin
`ifdef TAP_AVERAGE_EN
         if (!m_primed) m_hist = '{per, per, per, per};
         else           m_hist = '{per, m_hist[0], m_hist[1], m_hist[2]};
         m_primed = 1;
         val = (m_hist[0] + m_hist[1] + m_hist[2] + m_hist[3]) / 4;
`else
         val = per;
`endif
         if (m_valid && !period_ready_i) begin
            exp_ov++;
            if (exp_q.size() > 0) void'(exp_q.pop_back());
         end
         exp_q.push_back(W'(val));
         m_valid  = 1;
         m_period = W'(val);
      end else if (m_valid && period_ready_i) begin
         m_valid = 0;
      end
      if (period_valid_o && period_ready_i) got_q.push_back(period_o);
      @(posedge clk);
      #1;
      obs_to += int'(timeout_o);
      obs_ov += int'(overrun_o);
   endtask

   task automatic tps(input int n);
      for (int i = 0; i < n; i++) begin
         repeat ($urandom_range(0, 2)) cycle(m_btn, 1'b0);
         cycle(m_btn, 1'b1);
      end
   endtask

   task automatic press(input logic with_tp);
      cycle(1'b1, with_tp);
   endtask

   task automatic release_btn(input bit allow_tp);
      repeat ($urandom_range(0, 2)) cycle(1'b1, allow_tp ? 1'($urandom_range(0, 1)) : 1'b0);
      cycle(1'b0, 1'b0);
   endtask

   task automatic assert_reset();
      rst_i    = 1'b1;
      btn_i    = 1'b0;
      tp_i     = 1'b0;
      m_meas   = 0;
      m_btn    = 0;
      m_valid  = 0;
      m_primed = 0;
      exp_q.delete();
      got_q.delete();
      #2;
   endtask

   task automatic release_reset();
      @(posedge clk);
      #1;
      rst_i = 1'b0;
   endtask

   task automatic test_reset();
      assert_reset();
      total += 5;
      if (period_o !== '0) begin bad++; $display("FAIL reset_period got=%0d exp=0", period_o); end
      if (period_valid_o !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", period_valid_o); end
      if (timeout_o !== 1'b0) begin bad++; $display("FAIL reset_timeout got=%b exp=0", timeout_o); end
      if (overrun_o !== 1'b0) begin bad++; $display("FAIL reset_overrun got=%b exp=0", overrun_o); end
      if (state_o !== s_idle) begin bad++; $display("FAIL reset_state got=%0d exp=%0d", state_o, s_idle); end
      release_reset();
      tps(5);
      total += 2;
      if (state_o !== s_idle) begin bad++; $display("FAIL idle_tp_state got=%0d exp=%0d", state_o, s_idle); end
      if (period_valid_o !== 1'b0) begin bad++; $display("FAIL idle_tp_valid got=%b exp=0", period_valid_o); end
   endtask

   task automatic test_periodic();
      int to0;
      to0 = obs_to;
      period_ready_i = 1'b1;
      press(1'b0);
      release_btn(0);
      for (int k = 0; k < 2; k++) begin
         tps(40);
         press(1'b0);
         total += 2;
         if (period_valid_o !== 1'b1) begin bad++; $display("FAIL periodic_valid got=%b exp=1", period_valid_o); end
         if (period_o !== 7'd40) begin bad++; $display("FAIL periodic_period got=%0d exp=40", period_o); end
         release_btn(0);
      end
      total += 2;
      if (got_q.size() != 2) begin bad++; $display("FAIL periodic_xfers got=%0d exp=2", got_q.size()); end
      if (obs_to != to0) begin bad++; $display("FAIL periodic_timeout got=%0d exp=%0d", obs_to - to0, 0); end
   endtask

   task automatic test_too_fast();
      assert_reset();
      release_reset();
      period_ready_i = 1'b1;
      press(1'b0);
      release_btn(0);
      tps(5);
      press(1'b0);
      total += 1;
      if (period_valid_o !== 1'b0) begin bad++; $display("FAIL fast_tap_valid got=%b exp=0", period_valid_o); end
      release_btn(0);
      tps(35);
      press(1'b0);
      total += 1;
      if (period_o !== 7'd40) begin bad++; $display("FAIL fast_period got=%0d exp=40", period_o); end
      release_btn(0);
      total += 1;
      if (got_q.size() != 1) begin bad++; $display("FAIL fast_xfers got=%0d exp=1", got_q.size()); end
   endtask

   task automatic test_timeout();
      int to0;
      to0 = obs_to;
      press(1'b0);
      release_btn(0);
      tps(100);
      total += 2;
      if (obs_to != to0) begin bad++; $display("FAIL timeout_early got=%0d exp=%0d", obs_to - to0, 0); end
      if (state_o !== s_count) begin bad++; $display("FAIL timeout_pre_state got=%0d exp=%0d", state_o, s_count); end
      tps(1);
      total += 2;
      if (timeout_o !== 1'b1) begin bad++; $display("FAIL timeout_pulse got=%b exp=1", timeout_o); end
      if (state_o !== s_idle) begin bad++; $display("FAIL timeout_state got=%0d exp=%0d", state_o, s_idle); end
      cycle(1'b0, 1'b0);
      tps(5);
      total += 2;
      if (obs_to - to0 != 1) begin bad++; $display("FAIL timeout_count got=%0d exp=1", obs_to - to0); end
      if (obs_to != exp_to) begin bad++; $display("FAIL timeout_model got=%0d exp=%0d", obs_to, exp_to); end
      press(1'b0);
      release_btn(0);
      tps(40);
      press(1'b0);
      total += 1;
      if (period_o !== 7'd40) begin bad++; $display("FAIL restart_period got=%0d exp=40", period_o); end
      release_btn(0);
   endtask

   task automatic test_overrun();
      int ov0;
      assert_reset();
      release_reset();
      ov0 = obs_ov;
      period_ready_i = 1'b0;
      press(1'b0);
      release_btn(0);
      tps(30);
      press(1'b0);
      total += 2;
      if (period_o !== 7'd30) begin bad++; $display("FAIL ovr_first got=%0d exp=30", period_o); end
      if (overrun_o !== 1'b0) begin bad++; $display("FAIL ovr_first_flag got=%b exp=0", overrun_o); end
      release_btn(0);
      tps(50);
      total += 1;
      if (period_o !== 7'd30) begin bad++; $display("FAIL ovr_hold got=%0d exp=30", period_o); end
      press(1'b0);
      total += 3;
      if (period_o !== 7'd50) begin bad++; $display("FAIL ovr_second got=%0d exp=50", period_o); end
      if (overrun_o !== 1'b1) begin bad++; $display("FAIL ovr_flag got=%b exp=1", overrun_o); end
      if (period_valid_o !== 1'b1) begin bad++; $display("FAIL ovr_valid got=%b exp=1", period_valid_o); end
      cycle(1'b0, 1'b0);
      total += 2;
      if (overrun_o !== 1'b0) begin bad++; $display("FAIL ovr_pulse_len got=%b exp=0", overrun_o); end
      if (obs_ov - ov0 != 1) begin bad++; $display("FAIL ovr_count got=%0d exp=1", obs_ov - ov0); end
      period_ready_i = 1'b1;
      cycle(1'b0, 1'b0);
      total += 3;
      if (period_valid_o !== 1'b0) begin bad++; $display("FAIL ovr_drain_valid got=%b exp=0", period_valid_o); end
      if (got_q.size() != 1) begin bad++; $display("FAIL ovr_xfers got=%0d exp=1", got_q.size()); end
      else if (got_q[0] !== 7'd50) begin bad++; $display("FAIL ovr_xfer_val got=%0d exp=50", got_q[0]); end
   endtask

   task automatic test_tap_wins_and_reset();
      int to0;
      assert_reset();
      release_reset();
      to0 = obs_to;
      period_ready_i = 1'b1;
      press(1'b0);
      release_btn(0);
      tps(100);
      period_ready_i = 1'b0;
      press(1'b1);
      total += 3;
      if (period_o !== 7'd100) begin bad++; $display("FAIL tapwin_period got=%0d exp=100", period_o); end
      if (timeout_o !== 1'b0) begin bad++; $display("FAIL tapwin_timeout got=%b exp=0", timeout_o); end
      if (state_o !== s_count) begin bad++; $display("FAIL tapwin_state got=%0d exp=%0d", state_o, s_count); end
      release_btn(0);
      tps(20);
      assert_reset();
      total += 3;
      if (period_valid_o !== 1'b0) begin bad++; $display("FAIL midrst_valid got=%b exp=0", period_valid_o); end
      if (period_o !== '0) begin bad++; $display("FAIL midrst_period got=%0d exp=0", period_o); end
      if (state_o !== s_idle) begin bad++; $display("FAIL midrst_state got=%0d exp=%0d", state_o, s_idle); end
      release_reset();
      period_ready_i = 1'b1;
      press(1'b0);
      total += 1;
      if (period_valid_o !== 1'b0) begin bad++; $display("FAIL postrst_first got=%b exp=0", period_valid_o); end
      release_btn(0);
      tps(40);
      press(1'b0);
      total += 2;
      if (period_o !== 7'd40) begin bad++; $display("FAIL postrst_period got=%0d exp=40", period_o); end
      if (obs_to != to0) begin bad++; $display("FAIL tapwin_timeouts got=%0d exp=%0d", obs_to - to0, 0); end
      release_btn(0);
   endtask

   task automatic test_average();
      int per [4];
      int exp_v [4];
      per = '{40, 40, 40, 80};
`ifdef TAP_AVERAGE_EN
      exp_v = '{40, 40, 40, 50};
`else
      exp_v = '{40, 40, 40, 80};
`endif
      assert_reset();
      release_reset();
      period_ready_i = 1'b1;
      press(1'b0);
      release_btn(0);
      for (int k = 0; k < 4; k++) begin
         tps(per[k]);
         press(1'b0);
         total += 1;
         if (period_o !== W'(exp_v[k])) begin bad++; $display("FAIL avg_%0d got=%0d exp=%0d", k, period_o, exp_v[k]); end
         release_btn(0);
      end
   endtask

   task automatic test_random();
      assert_reset();
      release_reset();
      press(1'b0);
      release_btn(1);
      for (int k = 0; k < 25; k++) begin
         period_ready_i = ($urandom_range(0, 3) != 0);
         tps($urandom_range(0, 115));
         press(1'($urandom_range(0, 1)));
         total += 2;
         if (period_valid_o !== m_valid) begin bad++; $display("FAIL rnd_valid k=%0d got=%b exp=%b", k, period_valid_o, m_valid); end
         if (m_valid && period_o !== m_period) begin bad++; $display("FAIL rnd_period k=%0d got=%0d exp=%0d", k, period_o, m_period); end
         release_btn(1);
      end
      period_ready_i = 1'b1;
      cycle(1'b0, 1'b0);
      cycle(1'b0, 1'b0);
      total += 3;
      if (got_q.size() != exp_q.size()) begin bad++; $display("FAIL rnd_xfer_count got=%0d exp=%0d", got_q.size(), exp_q.size()); end
      if (obs_to != exp_to) begin bad++; $display("FAIL rnd_timeouts got=%0d exp=%0d", obs_to, exp_to); end
      if (obs_ov != exp_ov) begin bad++; $display("FAIL rnd_overruns got=%0d exp=%0d", obs_ov, exp_ov); end
      for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
         total++;
         if (got_q[i] !== exp_q[i]) begin bad++; $display("FAIL rnd_xfer_%0d got=%0d exp=%0d", i, got_q[i], exp_q[i]); end
      end
   endtask

   initial begin
      rst_i          = 1'b1;
      tp_i           = 1'b0;
      btn_i          = 1'b0;
      period_ready_i = 1'b1;
      m_tp           = 0;
      m_start        = 0;
      m_period       = '0;
      exp_to         = 0;
      exp_ov         = 0;
      obs_to         = 0;
      obs_ov         = 0;
      test_reset();
      test_periodic();
      test_too_fast();
      test_timeout();
      test_overrun();
      test_tap_wins_and_reset();
      test_average();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
